// File: rtl/adc0844_scanner_pkg.sv
// ---------------------------------------------------------------------------
// adc0844_scanner_pkg
//   Shared types and constants for the ADC0844 channel scanner.
//   - state_t      : scanner FSM states
//   - MA_*_BASE    : mux-address base codes (single-ended / differential)
//   - mux_code()   : builds the 4-bit mux address for a channel index
// ---------------------------------------------------------------------------
package adc0844_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_REL,
        ST_WAIT,
        ST_RD,
        ST_RD_REL,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [3:0] MA_SE_BASE   = 4'b0100;
    localparam logic [3:0] MA_DIFF_BASE = 4'b0000;

    // The channel index occupies the two low mux-address bits in both modes.
    function automatic logic [3:0] mux_code(input logic [1:0] ch, input logic diff);
        return (diff ? MA_DIFF_BASE : MA_SE_BASE) | {2'b00, ch};
    endfunction

endpackage

// File: rtl/adc0844_scanner_if.sv
// ---------------------------------------------------------------------------
// adc0844_scanner_if
//   Pin bundle between the scanner (master) and an ADC0844-style device
//   (slave).
//   - ma     : mux address           (master -> slave)
//   - cs_n   : chip select, low      (master -> slave)
//   - wr_n   : start-conversion strobe, low (master -> slave)
//   - rd_n   : read strobe, low      (master -> slave)
//   - db     : 8-bit result bus      (slave -> master)
//   - intr_n : end of conversion, low (slave -> master)
// ---------------------------------------------------------------------------
interface adc0844_scanner_if;

    logic [3:0] ma;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] db;
    logic       intr_n;

    modport master (
        output ma, cs_n, wr_n, rd_n,
        input  db, intr_n
    );

    modport slave (
        input  ma, cs_n, wr_n, rd_n,
        output db, intr_n
    );

endinterface

// File: rtl/adc0844_scanner.sv
// ---------------------------------------------------------------------------
// adc0844_scanner
//   Host-side initiator for a 4-channel ADC0844-style joystick ADC. Each scan
//   converts channels 0..3 in order: write strobe (latches mux address and
//   starts conversion), wait for intr_n, read strobe (samples db), next.
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : pulse to begin one scan (ignored while busy)
//   cont              : restart automatically after each completed scan
//   diff              : 0 single-ended, 1 differential (sampled per channel)
//   adc               : ADC pin bundle (master side)
//   res0..res3        : latest 8-bit result per channel
//   busy              : scan in progress
//   done              : one-cycle pulse when a scan completes
//   tmo               : per-channel timeout flags of the last scan
//
// Parameters:
//   WR_CYC  : cycles wr_n is held low (>= 1)
//   RD_CYC  : cycles rd_n is held low (>= 2); db sampled in the last one
//   TMO_CYC : cycles to wait for intr_n before declaring a timeout
// ---------------------------------------------------------------------------
module adc0844_scanner
    import adc0844_scanner_pkg::*;
#(
    parameter int WR_CYC  = 2,
    parameter int RD_CYC  = 3,
    parameter int TMO_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                cont,
    input  logic                diff,
    adc0844_scanner_if.master   adc,
    output logic [7:0]          res0,
    output logic [7:0]          res1,
    output logic [7:0]          res2,
    output logic [7:0]          res3,
    output logic                busy,
    output logic                done,
    output logic [3:0]          tmo
);

    // One shared up-counter serves strobe widths and the intr timeout.
    localparam int CNT_MAX = (TMO_CYC > WR_CYC) ?
                             ((TMO_CYC > RD_CYC) ? TMO_CYC : RD_CYC) :
                             ((WR_CYC > RD_CYC) ? WR_CYC : RD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    state_t           state_reg, state_next;
    logic [1:0]       idx_reg,   idx_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [3:0]       ma_reg,    ma_next;
    logic             done_q_reg;

    logic             cs_n_c, wr_n_c, rd_n_c;
    logic             res_we;
    logic [7:0]       res_val;
    logic             tmo_set;
    logic             tmo_clr;
    logic [31:0]      res_flat;

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= 2'd0;
            cnt_reg    <= '0;
            ma_reg     <= 4'd0;
            done_q_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            ma_reg     <= ma_next;
            done_q_reg <= (state_reg == ST_DONE);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg + 1'b1;
        ma_next    = ma_reg;
        cs_n_c     = 1'b1;
        wr_n_c     = 1'b1;
        rd_n_c     = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        res_we     = 1'b0;
        res_val    = adc.db;
        tmo_set    = 1'b0;
        tmo_clr    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy     = 1'b0;
                cnt_next = '0;
                // done_q_reg marks the IDLE cycle directly after DONE, which is
                // the only point where cont may restart a scan.
                if (start || (cont && done_q_reg)) begin
                    tmo_clr    = 1'b1;
                    idx_next   = 2'd0;
                    ma_next    = mux_code(2'd0, diff);
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                cs_n_c = 1'b0;
                wr_n_c = 1'b0;
                if (cnt_reg == WR_LAST) begin
                    state_next = ST_WR_REL;
                end
            end
            ST_WR_REL: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // intr_n has priority over the terminal count.
                if (!adc.intr_n) begin
                    state_next = ST_RD;
                end else if (cnt_reg == TMO_LAST) begin
                    res_we     = 1'b1;
                    res_val    = 8'd0;
                    tmo_set    = 1'b1;
                    state_next = ST_NEXT;
                end
            end
            ST_RD: begin
                cs_n_c = 1'b0;
                rd_n_c = 1'b0;
                if (cnt_reg == RD_LAST) begin
                    res_we     = 1'b1;
                    state_next = ST_RD_REL;
                end
            end
            ST_RD_REL: begin
                state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_reg == 2'd3) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg + 2'd1;
                    ma_next    = mux_code(idx_reg + 2'd1, diff);
                    state_next = ST_WR;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Every state starts its own count from zero.
        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    assign adc.ma   = ma_reg;
    assign adc.cs_n = cs_n_c;
    assign adc.wr_n = wr_n_c;
    assign adc.rd_n = rd_n_c;

    // -----------------------------------------------------------------------
    // Per-channel result and timeout registers
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [7:0] res_reg;
            logic       tmo_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    res_reg <= 8'd0;
                end else if (res_we && (idx_reg == 2'(gi))) begin
                    res_reg <= res_val;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    tmo_reg <= 1'b0;
                end else if (tmo_clr) begin
                    tmo_reg <= 1'b0;
                end else if (tmo_set && (idx_reg == 2'(gi))) begin
                    tmo_reg <= 1'b1;
                end
            end

            assign res_flat[gi*8 +: 8] = res_reg;
            assign tmo[gi]             = tmo_reg;
        end
    endgenerate

    assign res0 = res_flat[7:0];
    assign res1 = res_flat[15:8];
    assign res2 = res_flat[23:16];
    assign res3 = res_flat[31:24];

endmodule

// File: tb/tb_adc0844_scanner.sv
// ---------------------------------------------------------------------------
// tb_adc0844_scanner
//   Scoreboard bench: expected mux codes and per-scan results are queued when
//   a scan is requested and popped when the DUT strobes wr_n / pulses done.
//   Includes a small ADC0844 behavioural model and a pin-protocol monitor.
// ---------------------------------------------------------------------------
module tb_adc0844_scanner;
    import adc0844_scanner_pkg::*;

    localparam int WR_CYC  = 2;
    localparam int RD_CYC  = 3;
    localparam int TMO_CYC = 16;

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        logic [3:0] t;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       diff = 1'b0;
    logic [7:0] res0, res1, res2, res3;
    logic       busy, done;
    logic [3:0] tmo;

    adc0844_scanner_if adc_if ();

    adc0844_scanner #(
        .WR_CYC (WR_CYC),
        .RD_CYC (RD_CYC),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .cont   (cont),
        .diff   (diff),
        .adc    (adc_if),
        .res0   (res0),
        .res1   (res1),
        .res2   (res2),
        .res3   (res3),
        .busy   (busy),
        .done   (done),
        .tmo    (tmo)
    );

    always #5 clk = ~clk;

    // ---------------- check bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- ADC model ----------------
    logic [7:0] ch1 = 8'd10, ch2 = 8'd20, ch3 = 8'd30, ch4 = 8'd40;
    logic       intr_en = 1'b1;
    logic       wr_prev, intr_r;
    logic [7:0] conv;

    function automatic logic [7:0] sub_clamp(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    function automatic logic [7:0] adc_conv(input logic [3:0] m);
        logic [7:0] v;
        case (m)
            4'd4:    v = ch1;
            4'd5:    v = ch2;
            4'd6:    v = ch3;
            4'd7:    v = ch4;
            4'd0:    v = sub_clamp(ch1, ch2);
            4'd1:    v = sub_clamp(ch2, ch1);
            4'd2:    v = sub_clamp(ch3, ch4);
            4'd3:    v = sub_clamp(ch4, ch3);
            default: v = 8'hEE;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev <= 1'b1;
            intr_r  <= 1'b1;
            conv    <= 8'd0;
        end else begin
            wr_prev <= adc_if.wr_n;
            if (!adc_if.rd_n) begin
                intr_r <= 1'b1;
            end else if (!wr_prev && adc_if.wr_n && intr_en) begin
                conv   <= adc_conv(adc_if.ma);
                intr_r <= 1'b0;
            end
        end
    end

    assign adc_if.db     = conv;
    assign adc_if.intr_n = intr_r;

    // ---------------- scoreboard ----------------
    logic [3:0] ma_q[$];
    rec_t       exp_q[$];
    int         done_cnt = 0;
    logic       wr_mon_prev = 1'b1;

    task automatic push_scan(input logic d, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] e, input logic [3:0] t);
        rec_t r;
        for (int k = 0; k < 4; k++) ma_q.push_back((d ? 4'b0000 : 4'b0100) | 4'(k));
        r.r0 = a; r.r1 = b; r.r2 = c; r.r3 = e; r.t = t;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            // protocol rules
            chk("proto_wr_rd_overlap", {31'd0, !adc_if.wr_n && !adc_if.rd_n}, 32'd0);
            chk("proto_cs_no_strobe",
                {31'd0, !adc_if.cs_n && adc_if.wr_n && adc_if.rd_n}, 32'd0);
            // mux code at start of each write strobe
            if (wr_mon_prev && !adc_if.wr_n) begin
                if (ma_q.size() == 0) chk("ma_unexpected_wr", 32'd1, 32'd0);
                else chk("ma_code", {28'd0, adc_if.ma}, {28'd0, ma_q.pop_front()});
            end
            // results at each completed scan
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("scan_unexpected_done", 32'd1, 32'd0);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    chk("res0", {24'd0, res0}, {24'd0, r.r0});
                    chk("res1", {24'd0, res1}, {24'd0, r.r1});
                    chk("res2", {24'd0, res2}, {24'd0, r.r2});
                    chk("res3", {24'd0, res3}, {24'd0, r.r3});
                    chk("tmo",  {28'd0, tmo},  {28'd0, r.t});
                end
            end
        end
        wr_mon_prev = adc_if.wr_n;
    end

    // ---------------- helpers ----------------
    // Pulses start and measures cycles from the start edge to done.
    task automatic run_scan(input int exp_lat);
        int  n;
        bit  seen;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1; seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            n++;
        end
        chk("scan_finished", {31'd0, seen}, 32'd1);
        chk("scan_latency", n, exp_lat);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int busy_seen;
        busy_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk(tag, busy_seen, 0);
    endtask

    localparam int LAT_NOM = 4 * (WR_CYC + 1 + 1 + RD_CYC + 2) + 1;   // 37
    localparam int LAT_TMO = 4 * (WR_CYC + 1 + TMO_CYC + 1) + 1;      // 81

    // ---------------- stimulus ----------------
    initial begin
        int  dc;
        bit  seen;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'd0, adc_if.cs_n}, 32'd1);
        chk("rst_wr_n", {31'd0, adc_if.wr_n}, 32'd1);
        chk("rst_rd_n", {31'd0, adc_if.rd_n}, 32'd1);
        chk("rst_ma",   {28'd0, adc_if.ma},   32'd0);
        chk("rst_busy", {31'd0, busy},        32'd0);
        chk("rst_done", {31'd0, done},        32'd0);
        chk("rst_tmo",  {28'd0, tmo},         32'd0);
        chk("rst_res",  {res3, res2, res1, res0}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single-ended scan
        $display("scan single-ended 10/20/30/40");
        diff = 1'b0;
        push_scan(1'b0, 8'd10, 8'd20, 8'd30, 8'd40, 4'h0);
        dc = done_cnt;
        run_scan(LAT_NOM);
        expect_idle("se_idle_after", 5);
        chk("se_done_once", done_cnt - dc, 1);

        // 2: differential scan
        $display("scan differential 50/20/5/9");
        ch1 = 8'd50; ch2 = 8'd20; ch3 = 8'd5; ch4 = 8'd9;
        diff = 1'b1;
        push_scan(1'b1, 8'd30, 8'd0, 8'd0, 8'd4, 4'h0);
        run_scan(LAT_NOM);
        repeat (3) @(negedge clk);

        // 3: intr never asserted -> all channels time out after 16 WAIT cycles
        $display("scan with intr_n stuck high");
        diff = 1'b0; intr_en = 1'b0;
        push_scan(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF);
        run_scan(LAT_TMO);
        intr_en = 1'b1;
        repeat (3) @(negedge clk);

        // 4: continuous mode, ch1 changes after scan 1's channel-0 read
        $display("continuous scans, ch1 10 -> 99");
        ch1 = 8'd10; ch2 = 8'd20; ch3 = 8'd30; ch4 = 8'd40;
        push_scan(1'b0, 8'd10, 8'd20, 8'd30, 8'd40, 4'h0);
        push_scan(1'b0, 8'd99, 8'd20, 8'd30, 8'd40, 4'h0);
        push_scan(1'b0, 8'd99, 8'd20, 8'd30, 8'd40, 4'h0);
        cont = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!adc_if.rd_n) begin seen = 1'b1; break; end
        end
        chk("cont_first_rd", {31'd0, seen}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adc_if.rd_n) begin seen = 1'b1; break; end
        end
        chk("cont_first_rd_end", {31'd0, seen}, 32'd1);
        ch1 = 8'd99;
        for (int s = 0; s < 2; s++) begin
            wait_done("cont_done");
            @(negedge clk);
            chk("cont_gap_idle", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("cont_restart", {31'd0, busy}, 32'd1);
        end
        cont = 1'b0;
        wait_done("cont_done3");
        expect_idle("cont_stops", 6);

        // 5: reset during read of channel 2
        $display("reset during channel 2 read");
        ma_q.push_back(4'd4); ma_q.push_back(4'd5); ma_q.push_back(4'd6);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (adc_if.ma == 4'd6 && !adc_if.rd_n) begin seen = 1'b1; break; end
        end
        chk("rst_mid_reached_rd2", {31'd0, seen}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_cs_n", {31'd0, adc_if.cs_n}, 32'd1);
        chk("rst_mid_rd_n", {31'd0, adc_if.rd_n}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy},        32'd0);
        chk("rst_mid_res",  {res3, res2, res1, res0}, 32'd0);
        chk("rst_mid_tmo",  {28'd0, tmo},         32'd0);
        chk("rst_mid_maq",  ma_q.size(),          0);
        @(negedge clk); reset_n = 1'b1;
        push_scan(1'b0, 8'd99, 8'd20, 8'd30, 8'd40, 4'h0);
        run_scan(LAT_NOM);
        repeat (2) @(negedge clk);

        // 6: start while busy is ignored
        $display("start pulsed mid-scan");
        push_scan(1'b0, 8'd99, 8'd20, 8'd30, 8'd40, 4'h0);
        dc = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("busy_start_done");
        expect_idle("busy_start_not_queued", 10);
        chk("busy_start_one_scan", done_cnt - dc, 1);

        // 7: start and cont together give a single scan
        $display("start+cont together in IDLE");
        ch2 = 8'd77;
        push_scan(1'b0, 8'd99, 8'd77, 8'd30, 8'd40, 4'h0);
        dc = done_cnt;
        @(negedge clk); start = 1'b1; cont = 1'b1;
        @(negedge clk); start = 1'b0; cont = 1'b0;
        wait_done("sc_done");
        expect_idle("sc_single", 10);
        chk("sc_one_scan", done_cnt - dc, 1);

        chk("ma_q_drained",  ma_q.size(),  0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
